// File: rtl/registro_tablero_pkg.sv
// Shared constants and types for the tic-tac-toe board writer.
// Cell codes, FSM states and board size.
package registro_tablero_pkg;

    localparam int NUM_CELDAS = 9;

    localparam logic [1:0] VACIO = 2'b00;
    localparam logic [1:0] JUG_X = 2'b01;
    localparam logic [1:0] JUG_O = 2'b10;

    typedef enum logic {
        JUEGO = 1'b0,
        FIN   = 1'b1
    } estado_t;

    // Player that moves after the given one.
    function automatic logic [1:0] otro_jugador(input logic [1:0] j);
        return (j == JUG_X) ? JUG_O : JUG_X;
    endfunction

endpackage

// File: rtl/registro_tablero_if.sv
// Move request/response bundle and board outputs of the writer.
// master drives requests, slave is the board writer.
interface registro_tablero_if;
    logic       nuevo_juego;
    logic       mov_valido;
    logic [3:0] mov_pos;
    logic       fin_juego;
    logic [1:0] pos1, pos2, pos3;
    logic [1:0] pos4, pos5, pos6;
    logic [1:0] pos7, pos8, pos9;
    logic [1:0] turno;
    logic       mov_ack;
    logic       mov_error;
    logic [3:0] num_movs;
    logic       bloqueado;

    modport master (
        output nuevo_juego, mov_valido, mov_pos, fin_juego,
        input  pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        input  turno, mov_ack, mov_error, num_movs, bloqueado
    );

    modport slave (
        input  nuevo_juego, mov_valido, mov_pos, fin_juego,
        output pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
        output turno, mov_ack, mov_error, num_movs, bloqueado
    );
endinterface

// File: rtl/registro_tablero_decodificador_celda.sv
// One-hot decode of a 1..9 cell index.
// Out-of-range indices give no select and o_valido = 0.
module registro_tablero_decodificador_celda
    import registro_tablero_pkg::*;
(
    input  logic [3:0]            i_pos,
    output logic [NUM_CELDAS-1:0] o_sel,
    output logic                  o_valido
);

    // Range check, then set the single select bit.
    always_comb begin
        o_valido = (i_pos >= 4'd1) && (i_pos <= 4'd9);
        o_sel    = '0;
        if (o_valido) begin
            o_sel[i_pos - 4'd1] = 1'b1;
        end
    end

endmodule

// File: rtl/registro_tablero.sv
// Board-state writer: validates moves, writes cells, tracks turn.
// Freezes the board once the game is won or the board is full.
module registro_tablero
    import registro_tablero_pkg::*;
#(
    parameter logic [1:0] PRIMER_JUGADOR = 2'b01
) (
    input logic                clk,
    input logic                rst_n,
    registro_tablero_if.slave  tab
);

    logic [1:0]            r_celda [NUM_CELDAS];
    logic [1:0]            r_turno;
    logic [3:0]            r_num;
    logic                  r_ack;
    logic                  r_err;
    estado_t               r_estado;

    logic [NUM_CELDAS-1:0] w_sel;
    logic                  w_pos_ok;
    logic [NUM_CELDAS-1:0] w_ocup;
    logic                  w_ocupada;
    logic                  w_legal;

    registro_tablero_decodificador_celda u_dec (
        .i_pos    (tab.mov_pos),
        .o_sel    (w_sel),
        .o_valido (w_pos_ok)
    );

    // Occupancy of the addressed cell and move legality.
    always_comb begin
        for (int i = 0; i < NUM_CELDAS; i++) begin
            w_ocup[i] = (r_celda[i] != VACIO);
        end
        w_ocupada = |(w_sel & w_ocup);
        w_legal   = w_pos_ok && !w_ocupada && !tab.fin_juego;
    end

    // Game FSM with the board, turn, count and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CELDAS; i++) begin
                r_celda[i] <= VACIO;
            end
            r_turno  <= PRIMER_JUGADOR;
            r_num    <= 4'd0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_estado <= JUEGO;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (tab.nuevo_juego) begin
                for (int i = 0; i < NUM_CELDAS; i++) begin
                    r_celda[i] <= VACIO;
                end
                r_turno  <= PRIMER_JUGADOR;
                r_num    <= 4'd0;
                r_estado <= JUEGO;
            end else begin
                unique case (r_estado)
                    JUEGO: begin
                        if (tab.mov_valido && w_legal) begin
                            for (int i = 0; i < NUM_CELDAS; i++) begin
                                if (w_sel[i]) begin
                                    r_celda[i] <= r_turno;
                                end
                            end
                            r_turno <= otro_jugador(r_turno);
                            r_num   <= r_num + 4'd1;
                            r_ack   <= 1'b1;
                            if (r_num == 4'(NUM_CELDAS - 1)) begin
                                r_estado <= FIN;
                            end
                        end else begin
                            r_err <= tab.mov_valido;
                            if (tab.fin_juego) begin
                                r_estado <= FIN;
                            end
                        end
                    end
                    FIN: begin
                        r_err <= tab.mov_valido;
                    end
                    default: r_estado <= JUEGO;
                endcase
            end
        end
    end

    assign tab.pos1      = r_celda[0];
    assign tab.pos2      = r_celda[1];
    assign tab.pos3      = r_celda[2];
    assign tab.pos4      = r_celda[3];
    assign tab.pos5      = r_celda[4];
    assign tab.pos6      = r_celda[5];
    assign tab.pos7      = r_celda[6];
    assign tab.pos8      = r_celda[7];
    assign tab.pos9      = r_celda[8];
    assign tab.turno     = r_turno;
    assign tab.num_movs  = r_num;
    assign tab.mov_ack   = r_ack;
    assign tab.mov_error = r_err;
    assign tab.bloqueado = (r_estado == FIN);

endmodule

// File: tb/tb_registro_tablero.sv
// Self-checking bench for registro_tablero.
// Random and directed moves checked against a game-level model.
module tb_registro_tablero;

    logic clk;
    logic rst_n;

    registro_tablero_if tif ();

    registro_tablero #(.PRIMER_JUGADOR(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tab   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nerr;

    // Game model: board of player numbers, turn, count, frozen flag.
    int mb [9];
    int mturn;
    int mcnt;
    bit mfin;
    bit mack;
    bit merr;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mb[i] = 0;
        mturn = 1;
        mcnt  = 0;
        mfin  = 0;
        mack  = 0;
        merr  = 0;
    endtask

    function automatic logic [26:0] exp_vec();
        logic [26:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v = (v << 2) | 27'(mb[i]);
        v = (v << 2) | 27'(mturn);
        v = (v << 4) | 27'(mcnt);
        v = (v << 3) | 27'({mack, merr, mfin});
        return v;
    endfunction

    function automatic logic [26:0] dut_vec();
        return {tif.pos1, tif.pos2, tif.pos3, tif.pos4, tif.pos5,
                tif.pos6, tif.pos7, tif.pos8, tif.pos9, tif.turno,
                tif.num_movs, tif.mov_ack, tif.mov_error, tif.bloqueado};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic apply(input bit v, input int p, input bit f, input bit n);
        bit acc;
        tif.mov_valido  = v;
        tif.mov_pos     = 4'(p);
        tif.fin_juego   = f;
        tif.nuevo_juego = n;
        @(posedge clk);
        mack = 0;
        merr = 0;
        acc  = 0;
        if (n) begin
            model_reset();
        end else if (mfin) begin
            merr = v;
        end else begin
            if (v) begin
                if (p >= 1 && p <= 9 && mb[p-1] == 0 && !f) begin
                    mb[p-1] = mturn;
                    mturn   = 3 - mturn;
                    mcnt++;
                    mack = 1;
                    acc  = 1;
                    if (mcnt == 9) mfin = 1;
                end else begin
                    merr = 1;
                end
            end
            if (f && !acc) mfin = 1;
        end
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        tif.mov_valido  = 1'b0;
        tif.mov_pos     = 4'd0;
        tif.fin_juego   = 1'b0;
        tif.nuevo_juego = 1'b0;
        model_reset();
        #12;
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reset: got %h want %h", dut_vec(), exp_vec());
        end
        rst_n = 1'b1;
        #10;
    endtask

    task automatic test_first_move();
        apply(1, 5, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL first_move: got %h want %h", dut_vec(), exp_vec());
        end
        nvec++;
        if (tif.pos5 !== 2'b01 || tif.turno !== 2'b10 || tif.mov_ack !== 1'b1) begin
            nerr++;
            $display("FAIL first_move_x: got pos5=%b turno=%b ack=%b want 01 10 1",
                     tif.pos5, tif.turno, tif.mov_ack);
        end
        idle();
        nvec++;
        if (tif.mov_ack !== 1'b0) begin
            nerr++;
            $display("FAIL ack_pulse: got %b want 0", tif.mov_ack);
        end
    endtask

    task automatic test_occupied();
        apply(1, 5, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL occupied: got %h want %h", dut_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_bad_pos();
        apply(0, 0, 0, 1);
        apply(1, 0, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL pos0: got %h want %h", dut_vec(), exp_vec());
        end
        apply(1, 12, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL pos12: got %h want %h", dut_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_full_board();
        apply(0, 0, 0, 1);
        for (int c = 1; c <= 9; c++) begin
            apply(1, c, 0, 0);
            nvec++;
            if (dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL full_move%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
        end
        nvec++;
        if (tif.num_movs !== 4'd9 || tif.bloqueado !== 1'b1) begin
            nerr++;
            $display("FAIL full_lock: got num=%0d bloq=%b want 9 1",
                     tif.num_movs, tif.bloqueado);
        end
        apply(1, 4, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL tenth: got %h want %h", dut_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_fin_juego();
        apply(0, 0, 0, 1);
        apply(1, 1, 0, 0);
        apply(1, 2, 0, 0);
        apply(1, 3, 0, 0);
        apply(1, 7, 1, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL fin_move: got %h want %h", dut_vec(), exp_vec());
        end
        nvec++;
        if (tif.pos7 !== 2'b00 || tif.bloqueado !== 1'b1 || tif.mov_error !== 1'b1) begin
            nerr++;
            $display("FAIL fin_lock: got pos7=%b bloq=%b err=%b want 00 1 1",
                     tif.pos7, tif.bloqueado, tif.mov_error);
        end
        apply(0, 0, 0, 1);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL fin_new: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_nuevo_priority();
        apply(1, 1, 0, 0);
        apply(1, 3, 0, 1);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL nuevo_prio: got %h want %h", dut_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_back_to_back();
        apply(1, 4, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL b2b_first: got %h want %h", dut_vec(), exp_vec());
        end
        apply(1, 4, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL b2b_held: got %h want %h", dut_vec(), exp_vec());
        end
        apply(1, 6, 0, 0);
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL b2b_next: got %h want %h", dut_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 24) == 0,
                  $urandom_range(0, 29) == 0);
            nvec++;
            if (dut_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL random%0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        apply(0, 0, 0, 1);
        apply(1, 2, 0, 0);
        apply(1, 8, 0, 0);
        tif.mov_valido = 1'b1;
        tif.mov_pos    = 4'd5;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL async_reset: got %h want %h", dut_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        nvec++;
        if (dut_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_no_ack: got %h want %h", dut_vec(), exp_vec());
        end
        tif.mov_valido = 1'b0;
        #2;
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_first_move();
        test_occupied();
        test_bad_pos();
        test_full_board();
        test_fin_juego();
        test_nuevo_priority();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
